// File: rtl/blit_pkg.sv
// Shared definitions for the blitter command executor: opcodes, command field
// positions, FSM states and the power-on clip window.
package blit_pkg;

   typedef enum logic [7:0] {
      OP_NOP       = 8'h00,
      OP_SET_CLIP  = 8'h01,
      OP_FILL_RECT = 8'h02
   } blit_op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DECODE,
      ST_RUN
   } blit_state_e;

   localparam int CMD_W      = 96;
   localparam int OPCODE_LSB = 88;
   localparam int COLOR_LSB  = 64;
   localparam int X_LSB      = 48;
   localparam int Y_LSB      = 32;
   localparam int W_LSB      = 16;
   localparam int H_LSB      = 0;

   localparam logic [15:0] CLIP_X0_DEFAULT = 16'd0;
   localparam logic [15:0] CLIP_Y0_DEFAULT = 16'd0;
   localparam logic [15:0] CLIP_X1_DEFAULT = 16'd640;
   localparam logic [15:0] CLIP_Y1_DEFAULT = 16'd480;

   function automatic logic [15:0] sat16(input logic [16:0] v);
      return v[16] ? 16'hFFFF : v[15:0];
   endfunction

endpackage

// File: rtl/blit_rect_walker.sv
// Raster iterator for one clipped rectangle: emits pixel requests x-fastest on a
// valid/ready handshake and pulses done when the last pixel is accepted.
module blit_rect_walker
   import blit_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [15:0] xs,
   input  logic [16:0] xe,
   input  logic [15:0] ys,
   input  logic [16:0] ye,
   input  logic [15:0] color,
   input  logic        pix_ready,
   output logic        pix_valid,
   output logic [15:0] pix_x,
   output logic [15:0] pix_y,
   output logic [15:0] pix_color,
   output logic        done
);

   logic [16:0] x_q, x_d, y_q, y_d;
   logic [16:0] xe_q, xe_d, ye_q, ye_d;
   logic [15:0] xs_q, xs_d, color_q, color_d;
   logic        valid_q, valid_d;
   logic        unused_hi;

   // Counters are 17 bits so a span ending past 0xFFFF still terminates.
   always_comb begin
      x_d     = x_q;
      y_d     = y_q;
      xs_d    = xs_q;
      xe_d    = xe_q;
      ye_d    = ye_q;
      color_d = color_q;
      valid_d = valid_q;
      done    = 1'b0;
      if (start) begin
         x_d     = {1'b0, xs};
         y_d     = {1'b0, ys};
         xs_d    = xs;
         xe_d    = xe;
         ye_d    = ye;
         color_d = color;
         valid_d = 1'b1;
      end else if (valid_q && pix_ready) begin
         if (x_q + 17'd1 < xe_q) begin
            x_d = x_q + 17'd1;
         end else begin
            x_d = {1'b0, xs_q};
            if (y_q + 17'd1 < ye_q) begin
               y_d = y_q + 17'd1;
            end else begin
               valid_d = 1'b0;
               done    = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         x_q     <= '0;
         y_q     <= '0;
         xs_q    <= '0;
         xe_q    <= '0;
         ye_q    <= '0;
         color_q <= '0;
         valid_q <= 1'b0;
      end else begin
         x_q     <= x_d;
         y_q     <= y_d;
         xs_q    <= xs_d;
         xe_q    <= xe_d;
         ye_q    <= ye_d;
         color_q <= color_d;
         valid_q <= valid_d;
      end
   end

   assign pix_valid = valid_q;
   assign pix_x     = x_q[15:0];
   assign pix_y     = y_q[15:0];
   assign pix_color = color_q;
   assign unused_hi = x_q[16] ^ y_q[16];

endmodule

// File: rtl/blit_cmd_exec.sv
// Blitter command consumer: pops FIFO commands, decodes them and expands fills
// into pixel requests. Clip window support is built only with BLIT_CLIP_EN.
module blit_cmd_exec
   import blit_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   input  logic [CMD_W-1:0] cmd_in,
   input  logic             cmd_in_valid,
   output logic             next_cmd,
   output logic             pix_valid,
   input  logic             pix_ready,
   output logic [15:0]      pix_x,
   output logic [15:0]      pix_y,
   output logic [15:0]      pix_color,
   output logic             busy,
   output logic             illegal_cmd
);

   blit_state_e      state_q, state_d;
   logic [CMD_W-1:0] cmd_q, cmd_d;
   logic             illegal_q, illegal_d;

   logic [7:0]  f_op;
   logic [15:0] f_color, f_x, f_y, f_w, f_h;
   logic [16:0] x_end, y_end;
   logic [15:0] bnd_xs, bnd_ys;
   logic [16:0] bnd_xe, bnd_ye;
   logic        fill_empty;
   logic        walk_start, walk_done;
   logic        unused_ignored;

   assign f_op           = cmd_q[OPCODE_LSB +: 8];
   assign f_color        = cmd_q[COLOR_LSB +: 16];
   assign f_x            = cmd_q[X_LSB +: 16];
   assign f_y            = cmd_q[Y_LSB +: 16];
   assign f_w            = cmd_q[W_LSB +: 16];
   assign f_h            = cmd_q[H_LSB +: 16];
   assign unused_ignored = ^cmd_q[87:80];

   assign x_end = {1'b0, f_x} + {1'b0, f_w};
   assign y_end = {1'b0, f_y} + {1'b0, f_h};

`ifdef BLIT_CLIP_EN
   logic [15:0] clip_x0_q, clip_x0_d, clip_y0_q, clip_y0_d;
   logic [15:0] clip_x1_q, clip_x1_d, clip_y1_q, clip_y1_d;

   assign bnd_xs = (f_x > clip_x0_q) ? f_x : clip_x0_q;
   assign bnd_ys = (f_y > clip_y0_q) ? f_y : clip_y0_q;
   assign bnd_xe = (x_end < {1'b0, clip_x1_q}) ? x_end : {1'b0, clip_x1_q};
   assign bnd_ye = (y_end < {1'b0, clip_y1_q}) ? y_end : {1'b0, clip_y1_q};
`else
   assign bnd_xs = f_x;
   assign bnd_ys = f_y;
   assign bnd_xe = x_end;
   assign bnd_ye = y_end;
`endif

   assign fill_empty = ({1'b0, bnd_xs} >= bnd_xe) || ({1'b0, bnd_ys} >= bnd_ye);

   // Pops only from IDLE, so the FIFO head is always consumed one command at a time.
   always_comb begin
      state_d    = state_q;
      cmd_d      = cmd_q;
      illegal_d  = illegal_q;
      next_cmd   = 1'b0;
      walk_start = 1'b0;
`ifdef BLIT_CLIP_EN
      clip_x0_d  = clip_x0_q;
      clip_y0_d  = clip_y0_q;
      clip_x1_d  = clip_x1_q;
      clip_y1_d  = clip_y1_q;
`endif
      case (state_q)
         ST_IDLE: begin
            next_cmd = cmd_in_valid;
            if (cmd_in_valid) begin
               cmd_d   = cmd_in;
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: begin
            state_d = ST_IDLE;
            case (f_op)
               OP_NOP: begin
               end
               OP_SET_CLIP: begin
`ifdef BLIT_CLIP_EN
                  clip_x0_d = f_x;
                  clip_y0_d = f_y;
                  clip_x1_d = sat16(x_end);
                  clip_y1_d = sat16(y_end);
`endif
               end
               OP_FILL_RECT: begin
                  if (!fill_empty) begin
                     walk_start = 1'b1;
                     state_d    = ST_RUN;
                  end
               end
               default: illegal_d = 1'b1;
            endcase
         end
         ST_RUN: begin
            if (walk_done) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         cmd_q     <= '0;
         illegal_q <= 1'b0;
`ifdef BLIT_CLIP_EN
         clip_x0_q <= CLIP_X0_DEFAULT;
         clip_y0_q <= CLIP_Y0_DEFAULT;
         clip_x1_q <= CLIP_X1_DEFAULT;
         clip_y1_q <= CLIP_Y1_DEFAULT;
`endif
      end else begin
         state_q   <= state_d;
         cmd_q     <= cmd_d;
         illegal_q <= illegal_d;
`ifdef BLIT_CLIP_EN
         clip_x0_q <= clip_x0_d;
         clip_y0_q <= clip_y0_d;
         clip_x1_q <= clip_x1_d;
         clip_y1_q <= clip_y1_d;
`endif
      end
   end

   blit_rect_walker u_walker (
      .clock     (clock),
      .reset     (reset),
      .start     (walk_start),
      .xs        (bnd_xs),
      .xe        (bnd_xe),
      .ys        (bnd_ys),
      .ye        (bnd_ye),
      .color     (f_color),
      .pix_ready (pix_ready),
      .pix_valid (pix_valid),
      .pix_x     (pix_x),
      .pix_y     (pix_y),
      .pix_color (pix_color),
      .done      (walk_done)
   );

   assign busy        = (state_q != ST_IDLE);
   assign illegal_cmd = illegal_q;

endmodule
